datapath_delay_adj_gen: RTL and testbench



---
 rtl/datapath_delay_adj_gen.sv | 126 ++++++++++++
 tb/tb_datapath_delay_adj_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/datapath_delay_adj_gen.sv
// Read-side frame header generator for the BRAM delay line.
// Follows the incoming frame header, flywheels across missing headers,
// reports lock, and emits o_adjust_hd a programmed delay after each frame start.
module datapath_delay_adj_gen #(
   parameter logic [25:0] FRAM_MAX  = 26'd2457599,
   parameter logic [13:0] DELAY_MAX = 14'd1535,
   parameter int unsigned LOCK_NUM  = 3,
   parameter int unsigned LOSS_NUM  = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_fram_hd,
   input  logic [13:0] i_delay,
   input  logic        i_delay_vld,
   output logic        o_adjust_hd,
   output logic        o_lock,
   output logic        o_delay_err,
   output logic [13:0] o_cur_delay
);

   localparam logic [2:0] LOCK_N  = 3'(LOCK_NUM);
   localparam logic [2:0] LOSS_N  = 3'(LOSS_NUM);
   localparam logic [2:0] CNT_SAT = 3'd7;

   // The delay must land inside one frame, otherwise a pulse could be skipped.
   if ({12'd0, DELAY_MAX} >= FRAM_MAX) begin : g_bad_delay_max
      $error("DELAY_MAX must be smaller than FRAM_MAX");
   end

   typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

   state_t      state, state_nx;
   logic [25:0] fcnt, fcnt_nx;
   logic [2:0]  good_cnt, good_nx;
   logic [2:0]  miss_cnt, miss_nx;
   logic [13:0] pend_delay;
   logic        frame_start;

   // Next-state logic: header classification, flywheel and frame counter.
   always_comb begin
      state_nx    = state;
      fcnt_nx     = fcnt;
      good_nx     = good_cnt;
      miss_nx     = miss_cnt;
      frame_start = 1'b0;
      case (state)
         IDLE: begin
            fcnt_nx = '0;
            if (i_fram_hd) begin
               frame_start = 1'b1;
               good_nx     = 3'd1;
               miss_nx     = '0;
               state_nx    = ACQ;
            end
         end
         default: begin
            if (i_fram_hd) begin
               frame_start = 1'b1;
               fcnt_nx     = '0;
               miss_nx     = '0;
               if (fcnt == FRAM_MAX) begin
                  good_nx = (good_cnt == CNT_SAT) ? good_cnt : good_cnt + 3'd1;
                  if ((state == ACQ) && (good_nx >= LOCK_N)) begin
                     state_nx = LOCKED;
                  end
               end else begin
                  good_nx  = 3'd1;
                  state_nx = ACQ;
               end
            end else if (fcnt == FRAM_MAX) begin
               frame_start = 1'b1;
               fcnt_nx     = '0;
               good_nx     = '0;
               miss_nx     = (miss_cnt == CNT_SAT) ? miss_cnt : miss_cnt + 3'd1;
               if (miss_nx >= LOSS_N) begin
                  state_nx = IDLE;
               end
            end else begin
               fcnt_nx = fcnt + 26'd1;
            end
         end
      endcase
   end

   // State, counters, lock flag and the registered output pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         fcnt        <= '0;
         good_cnt    <= '0;
         miss_cnt    <= '0;
         o_lock      <= 1'b0;
         o_adjust_hd <= 1'b0;
      end else begin
         state       <= state_nx;
         fcnt        <= fcnt_nx;
         good_cnt    <= good_nx;
         miss_cnt    <= miss_nx;
         o_lock      <= (state_nx == LOCKED);
         o_adjust_hd <= (state != IDLE) && (fcnt == {12'd0, o_cur_delay});
      end
   end

   // Delay write with clamping, applied only at frame starts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_delay  <= '0;
         o_delay_err <= 1'b0;
         o_cur_delay <= '0;
      end else begin
         if (i_delay_vld) begin
            if (i_delay > DELAY_MAX) begin
               pend_delay  <= DELAY_MAX;
               o_delay_err <= 1'b1;
            end else begin
               pend_delay  <= i_delay;
               o_delay_err <= 1'b0;
            end
         end
         if (frame_start) begin
            o_cur_delay <= pend_delay;
         end
      end
   end

endmodule

// File: tb/tb_datapath_delay_adj_gen.sv
// Directed bench for datapath_delay_adj_gen: basic timing, delay change,
// flywheel/loss, early header, delay extremes, out-of-range and async reset.
module tb_datapath_delay_adj_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_fram_hd = 1'b0;
   logic [13:0] i_delay = '0;
   logic        i_delay_vld = 1'b0;
   logic        o_adjust_hd, o_lock, o_delay_err;
   logic [13:0] o_cur_delay;

   logic        b_fram_hd = 1'b0;
   logic [13:0] b_delay = '0;
   logic        b_delay_vld = 1'b0;
   logic        b_adjust_hd, b_lock, b_delay_err;
   logic [13:0] b_cur_delay;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   int hd_q[$];
   int wr_cyc_q[$];
   int wr_val_q[$];
   int pulse_q[$];
   int lock_cyc_q[$];
   int lock_val_q[$];
   int cd_cyc_q[$];
   int cd_val_q[$];

   always #5 clk = ~clk;

   datapath_delay_adj_gen #(
      .FRAM_MAX (26'd999),
      .DELAY_MAX(14'd900),
      .LOCK_NUM (3),
      .LOSS_NUM (3)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .i_fram_hd  (i_fram_hd),
      .i_delay    (i_delay),
      .i_delay_vld(i_delay_vld),
      .o_adjust_hd(o_adjust_hd),
      .o_lock     (o_lock),
      .o_delay_err(o_delay_err),
      .o_cur_delay(o_cur_delay)
   );

   datapath_delay_adj_gen #(
      .FRAM_MAX (26'd1999),
      .DELAY_MAX(14'd1535),
      .LOCK_NUM (3),
      .LOSS_NUM (3)
   ) u_oor (
      .clk        (clk),
      .rst        (rst),
      .i_fram_hd  (b_fram_hd),
      .i_delay    (b_delay),
      .i_delay_vld(b_delay_vld),
      .o_adjust_hd(b_adjust_hd),
      .o_lock     (b_lock),
      .o_delay_err(b_delay_err),
      .o_cur_delay(b_cur_delay)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic bit in_q(input int q[$], input int v);
      foreach (q[i]) if (q[i] == v) return 1'b1;
      return 1'b0;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      i_fram_hd = 1'b0; i_delay_vld = 1'b0;
      b_fram_hd = 1'b0; b_delay_vld = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_adj", o_adjust_hd, 0);
      check("rst_lock", o_lock, 0);
      check("rst_err", o_delay_err, 0);
      check("rst_cur", o_cur_delay, 0);
      check("rst_b_cur", b_cur_delay, 0);
      rst = 1'b0;
   endtask

   task automatic clear_q();
      hd_q.delete(); wr_cyc_q.delete(); wr_val_q.delete(); pulse_q.delete();
      lock_cyc_q.delete(); lock_val_q.delete(); cd_cyc_q.delete(); cd_val_q.delete();
   endtask

   // One negedge per cycle: check outputs of cycle c, then drive inputs for cycle c.
   task automatic run_scn(input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         cyc = c;
         check("adj_hd", o_adjust_hd, int'(in_q(pulse_q, c)));
         foreach (lock_cyc_q[i]) if (lock_cyc_q[i] == c) check("lock", o_lock, lock_val_q[i]);
         foreach (cd_cyc_q[i]) if (cd_cyc_q[i] == c) check("cur_delay", o_cur_delay, cd_val_q[i]);
         i_fram_hd = in_q(hd_q, c);
         i_delay_vld = 1'b0;
         foreach (wr_cyc_q[i]) begin
            if (wr_cyc_q[i] == c) begin
               i_delay_vld = 1'b1;
               i_delay = 14'(wr_val_q[i]);
            end
         end
      end
      i_fram_hd = 1'b0;
      i_delay_vld = 1'b0;
      clear_q();
   endtask

   initial begin
      clear_q();

      // Basic timing, lock, then flywheel and loss (D=100).
      do_reset();
      wr_cyc_q = '{10}; wr_val_q = '{100};
      hd_q = '{50, 1050, 2050};
      pulse_q = '{152, 1152, 2152, 3152, 4152};
      lock_cyc_q = '{2050, 2051, 4152, 5050, 5051};
      lock_val_q = '{0, 1, 1, 1, 0};
      cd_cyc_q = '{50, 51};
      cd_val_q = '{0, 100};
      run_scn(5300);

      // Delay change mid-frame takes effect at the next frame start.
      do_reset();
      wr_cyc_q = '{10, 1500}; wr_val_q = '{100, 10};
      hd_q = '{50, 1050, 2050, 3050};
      pulse_q = '{152, 1152, 2062, 3062};
      cd_cyc_q = '{1600, 2050, 2051};
      cd_val_q = '{100, 100, 10};
      run_scn(3100);
      check("err_in_range", o_delay_err, 0);

      // Early header while locked: resync, drop old pulse, re-lock.
      do_reset();
      wr_cyc_q = '{10}; wr_val_q = '{100};
      hd_q = '{50, 1050, 2050, 2500, 3500, 4500};
      pulse_q = '{152, 1152, 2152, 2602, 3602, 4602};
      lock_cyc_q = '{2051, 2500, 2501, 3501, 4500, 4501};
      lock_val_q = '{1, 1, 0, 0, 0, 1};
      run_scn(4700);

      // Delay extremes: D=0, then D=DELAY_MAX.
      do_reset();
      wr_cyc_q = '{10, 60}; wr_val_q = '{0, 900};
      hd_q = '{50, 1050};
      pulse_q = '{52, 1952};
      cd_cyc_q = '{1050, 1051};
      cd_val_q = '{0, 900};
      run_scn(2000);

      // Asynchronous reset during the pulse cycle, then restart.
      do_reset();
      wr_cyc_q = '{10}; wr_val_q = '{100};
      hd_q = '{50, 1050, 2050};
      pulse_q = '{152, 1152};
      lock_cyc_q = '{2151};
      lock_val_q = '{1};
      run_scn(2152);
      @(negedge clk);
      cyc = 2152;
      check("pre_rst_pulse", o_adjust_hd, 1);
      #1 rst = 1'b1;
      #1;
      check("async_adj", o_adjust_hd, 0);
      check("async_lock", o_lock, 0);
      check("async_cur", o_cur_delay, 0);
      repeat (3) @(negedge clk);
      check("hold_adj", o_adjust_hd, 0);
      rst = 1'b0;
      wr_cyc_q = '{5}; wr_val_q = '{20};
      hd_q = '{50};
      pulse_q = '{72};
      lock_cyc_q = '{51};
      lock_val_q = '{0};
      cd_cyc_q = '{51};
      cd_val_q = '{20};
      run_scn(200);

      // Out-of-range delay on the full-depth instance.
      do_reset();
      for (int c = 0; c < 1610; c++) begin
         @(negedge clk);
         cyc = c;
         if (c == 6) begin
            check("oor_err_set", b_delay_err, 1);
            check("oor_cur_pending", b_cur_delay, 0);
         end
         if (c == 11) check("oor_cur_clamped", b_cur_delay, 1535);
         if (c == 1546) check("oor_pulse_early", b_adjust_hd, 0);
         if (c == 1547) check("oor_pulse", b_adjust_hd, 1);
         if (c == 1548) check("oor_pulse_end", b_adjust_hd, 0);
         if (c == 1601) check("oor_err_clr", b_delay_err, 0);
         b_fram_hd = (c == 10);
         b_delay_vld = (c == 5) || (c == 1600);
         b_delay = (c == 5) ? 14'd2000 : 14'd5;
      end
      b_fram_hd = 1'b0;
      b_delay_vld = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
